// File: rtl/dm_pkg.sv
// Shared data-memory definitions for the MEM stage and its port arbiter.
// Holds the arbiter state type, default depth and load/store opcodes.
package dm_pkg;

  typedef enum logic {
    CLEAR,
    RUN
  } dm_state_t;

  localparam int DM_ADDR_W = 10;

  localparam logic [5:0] op_lw = 6'b100011;
  localparam logic [5:0] op_sw = 6'b101011;

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Bus bundle around the data-memory arbiter: CPU side,
// external master side and the one-port memory side.
interface dm_port_arbiter_if #(
  parameter int ADDR_W = 10
) ();

  logic              cpu_re;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;

  logic              ext_req;
  logic              ext_we;
  logic [31:0]       ext_addr;
  logic [31:0]       ext_wdata;
  logic              ext_gnt;
  logic [31:0]       ext_rdata;
  logic              ext_rvalid;

  logic              busy;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  cpu_re, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_gnt, ext_rdata, ext_rvalid,
    output busy,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_re, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_gnt, ext_rdata, ext_rvalid,
    input  busy,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dm_clear_seq.sv
// Post-reset clear sweep index counter; done marks the last word.
// Counts only while enabled and wraps back to zero after the last index.
module dm_clear_seq
  import dm_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [ADDR_W-1:0] idx,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
    end else if (en) begin
      idx <= idx + 1'b1;
    end
  end

  assign done = en && (idx == LAST);

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the data-memory port between the MEM stage and an external
// master, with a clear sweep after reset and a starvation guard.
module dm_port_arbiter
  import dm_pkg::*;
#(
  parameter int ADDR_W       = DM_ADDR_W,
  parameter int STARVE_LIMIT = 4,
  parameter bit CLEAR_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  dm_port_arbiter_if.slave bus
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  dm_state_t         state_q;
  dm_state_t         state_d;
  logic [3:0]        starve_q;
  logic [31:0]       ext_rdata_q;
  logic              ext_rvalid_q;
  logic [ADDR_W-1:0] clr_idx;
  logic              clr_done;

  logic [ADDR_W-1:0] cpu_idx;
  logic [ADDR_W-1:0] ext_idx;
  logic              cpu_acc;
  logic              forced;
  logic              gnt;
  logic              stall;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;

  dm_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clr (
    .clk  (clk),
    .reset(reset),
    .en   (state_q == CLEAR),
    .idx  (clr_idx),
    .done (clr_done)
  );

  assign cpu_idx = bus.cpu_addr[ADDR_W+1:2];
  assign ext_idx = bus.ext_addr[ADDR_W+1:2];
  assign cpu_acc = bus.cpu_re | bus.cpu_we;
  assign forced  = bus.ext_req && (starve_q == LIM);

  always_comb begin
    state_d = state_q;
    gnt     = 1'b0;
    stall   = 1'b0;
    we      = 1'b0;
    addr    = cpu_idx;
    wdata   = bus.cpu_wdata;
    if (state_q == CLEAR) begin
      stall = 1'b1;
      we    = 1'b1;
      addr  = clr_idx;
      wdata = '0;
      if (clr_done) state_d = RUN;
    end else if (forced) begin
      gnt   = 1'b1;
      stall = cpu_acc;
      we    = bus.ext_we;
      addr  = ext_idx;
      wdata = bus.ext_wdata;
    end else if (cpu_acc) begin
      we    = bus.cpu_we;
    end else if (bus.ext_req) begin
      gnt   = 1'b1;
      we    = bus.ext_we;
      addr  = ext_idx;
      wdata = bus.ext_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CLEAR_EN ? CLEAR : RUN;
      starve_q     <= '0;
      ext_rdata_q  <= '0;
      ext_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ext_rvalid_q <= gnt && !bus.ext_we;
      if (gnt && !bus.ext_we) ext_rdata_q <= bus.mem_rdata;
      // Losses are only counted once the port is actually contended in RUN
      if (state_q == RUN && bus.ext_req && !gnt)
        starve_q <= (starve_q == LIM) ? LIM : starve_q + 4'd1;
      else
        starve_q <= '0;
    end
  end

  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.cpu_stall  = stall;
  assign bus.ext_gnt    = gnt;
  assign bus.ext_rdata  = ext_rdata_q;
  assign bus.ext_rvalid = ext_rvalid_q;
  assign bus.busy       = (state_q == CLEAR);
  assign bus.mem_we     = we;
  assign bus.mem_addr   = addr;
  assign bus.mem_wdata  = wdata;

  logic unused;
  assign unused = ^{bus.cpu_addr[31:ADDR_W+2], bus.cpu_addr[1:0],
                    bus.ext_addr[31:ADDR_W+2], bus.ext_addr[1:0]};

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural 1024-word memory.
// Covers the clear sweep, CPU and external access, starvation and resets.
`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
    end \
  end

module tb_dm_port_arbiter;

  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem [DEPTH];

  dm_port_arbiter_if #(.ADDR_W(AW)) bus ();

  dm_port_arbiter #(
    .ADDR_W      (AW),
    .STARVE_LIMIT(4),
    .CLEAR_EN    (1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_re    = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.ext_req   = 1'b0;
    bus.ext_we    = 1'b0;
    bus.ext_addr  = '0;
    bus.ext_wdata = '0;
  endtask

  initial begin
    int bad;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA5A5_0000 | i;
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;

    // cycle 0 after reset release
    `CHK("rst_busy", bus.busy, 1'b1)
    `CHK("rst_stall", bus.cpu_stall, 1'b1)
    `CHK("rst_gnt", bus.ext_gnt, 1'b0)
    `CHK("rst_rvalid", bus.ext_rvalid, 1'b0)
    `CHK("rst_rdata", bus.ext_rdata, 32'h0)
    `CHK("rst_mem_we", bus.mem_we, 1'b1)
    `CHK("rst_mem_addr", bus.mem_addr, 10'd0)
    `CHK("rst_mem_wdata", bus.mem_wdata, 32'h0)

    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.busy !== 1'b1 || bus.mem_we !== 1'b1 ||
          bus.mem_addr !== 10'(i) || bus.mem_wdata !== 32'h0 ||
          bus.ext_gnt !== 1'b0)
        bad++;
      tick();
      #1;
    end
    `CHK("sweep_bad_cycles", bad, 0)

    // cycle 1024: first RUN cycle
    bus.cpu_re = 1'b1;
    #1;
    `CHK("run_busy", bus.busy, 1'b0)
    `CHK("run_stall", bus.cpu_stall, 1'b0)
    `CHK("clr_word0", mem[0], 32'h0)
    `CHK("clr_word1023", mem[1023], 32'h0)
    `CHK("clr_word512", mem[512], 32'h0)
    tick();

    // CPU store then load
    bus.cpu_re    = 1'b0;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 32'h10;
    bus.cpu_wdata = 32'hDEADBEEF;
    #1;
    `CHK("st_mem_addr", bus.mem_addr, 10'd4)
    `CHK("st_mem_we", bus.mem_we, 1'b1)
    `CHK("st_mem_wdata", bus.mem_wdata, 32'hDEADBEEF)
    `CHK("st_stall", bus.cpu_stall, 1'b0)
    tick();
    bus.cpu_we = 1'b0;
    bus.cpu_re = 1'b1;
    #1;
    `CHK("ld_rdata", bus.cpu_rdata, 32'hDEADBEEF)
    `CHK("ld_stall", bus.cpu_stall, 1'b0)
    `CHK("ld_mem_we", bus.mem_we, 1'b0)
    tick();

    // external read with CPU idle
    bus.cpu_re   = 1'b0;
    bus.ext_req  = 1'b1;
    bus.ext_we   = 1'b0;
    bus.ext_addr = 32'h10;
    #1;
    `CHK("xr_gnt", bus.ext_gnt, 1'b1)
    `CHK("xr_mem_we", bus.mem_we, 1'b0)
    tick();
    bus.ext_req = 1'b0;
    #1;
    `CHK("xr_rvalid", bus.ext_rvalid, 1'b1)
    `CHK("xr_rdata", bus.ext_rdata, 32'hDEADBEEF)
    `CHK("xr_gnt_off", bus.ext_gnt, 1'b0)
    tick();
    `CHK("xr_rvalid_off", bus.ext_rvalid, 1'b0)

    // starvation: CPU busy every cycle, ext write waiting
    bus.cpu_re    = 1'b1;
    bus.cpu_addr  = 32'h0;
    bus.ext_req   = 1'b1;
    bus.ext_we    = 1'b1;
    bus.ext_addr  = 32'h20;
    bus.ext_wdata = 32'h55;
    for (int c = 1; c <= 4; c++) begin
      #1;
      `CHK("sv_gnt_low", bus.ext_gnt, 1'b0)
      `CHK("sv_stall_low", bus.cpu_stall, 1'b0)
      tick();
    end
    #1;
    `CHK("sv_gnt5", bus.ext_gnt, 1'b1)
    `CHK("sv_stall5", bus.cpu_stall, 1'b1)
    `CHK("sv_addr5", bus.mem_addr, 10'd8)
    `CHK("sv_we5", bus.mem_we, 1'b1)
    `CHK("sv_rvalid_wr", bus.ext_rvalid, 1'b0)
    tick();
    bus.ext_req = 1'b0;
    #1;
    `CHK("sv_gnt6", bus.ext_gnt, 1'b0)
    `CHK("sv_stall6", bus.cpu_stall, 1'b0)
    `CHK("sv_rvalid6", bus.ext_rvalid, 1'b0)
    tick();
    bus.cpu_addr = 32'h20;
    #1;
    `CHK("sv_readback", bus.cpu_rdata, 32'h55)
    tick();

    // reset in the middle of a sweep
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 500; i++) tick();
    #1;
    `CHK("ms_addr500", bus.mem_addr, 10'd500)
    `CHK("ms_busy500", bus.busy, 1'b1)
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    `CHK("ms_addr0", bus.mem_addr, 10'd0)
    `CHK("ms_busy0", bus.busy, 1'b1)
    for (int i = 0; i < 1023; i++) tick();
    #1;
    `CHK("ms_addr1023", bus.mem_addr, 10'd1023)
    `CHK("ms_busy1023", bus.busy, 1'b1)
    tick();
    #1;
    `CHK("ms_busy1024", bus.busy, 1'b0)
    `CHK("ms_stall1024", bus.cpu_stall, 1'b0)

    // reset while an external request is pending with starve count 3
    bus.cpu_re    = 1'b1;
    bus.cpu_addr  = 32'h0;
    bus.ext_req   = 1'b1;
    bus.ext_we    = 1'b1;
    bus.ext_addr  = 32'h24;
    bus.ext_wdata = 32'h77;
    for (int c = 1; c <= 3; c++) tick();
    #1;
    `CHK("ma_gnt_pre", bus.ext_gnt, 1'b0)
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 10) bus.ext_req = 1'b0;
      #1;
      if (bus.ext_gnt !== 1'b0 || bus.busy !== 1'b1) bad++;
      tick();
    end
    `CHK("ma_sweep_no_gnt", bad, 0)
    `CHK("ma_word9_cleared", mem[9], 32'h0)
    bus.ext_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      `CHK("ma_gnt_low", bus.ext_gnt, 1'b0)
      tick();
    end
    #1;
    `CHK("ma_gnt5", bus.ext_gnt, 1'b1)
    `CHK("ma_stall5", bus.cpu_stall, 1'b1)
    `CHK("ma_addr5", bus.mem_addr, 10'd9)
    tick();
    bus.ext_req  = 1'b0;
    bus.cpu_addr = 32'h24;
    #1;
    `CHK("ma_readback", bus.cpu_rdata, 32'h77)
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
